// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared FSM encoding and width helper for the round-robin one-hot arbiter.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Requester/arbiter bundle: level requests and done in, registered grant out.
interface arb_if #(
    parameter int N    = 16,
    parameter int IDXW = arb_pkg::clog2(N)
);
    logic [N-1:0]    req;
    logic            done;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic [N-1:0]    grant_onehot;
    logic            timeout;

    modport master (
        output req, done,
        input  grant_valid, grant_idx, grant_onehot, timeout
    );

    modport slave (
        input  req, done,
        output grant_valid, grant_idx, grant_onehot, timeout
    );
endinterface

// File: rtl/rr_onehot_arbiter_find_next.sv
// First set request at or after start, wrapping modulo N; optional masked bit.
// Purely combinational; no handshake of its own.
module rr_find_next #(
    parameter int N    = 16,
    parameter int IDXW = 4
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] start,
    input  logic [IDXW-1:0] mask_idx,
    input  logic            use_mask,
    output logic            found,
    output logic [IDXW-1:0] idx
);
    logic [N-1:0]    req_m;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [IDXW:0]   pos;
    logic [IDXW-1:0] off;
    logic [IDXW:0]   sum;

    always_comb begin
        req_m = req;
        for (int i = 0; i < N; i++) begin
            if (use_mask && (mask_idx == IDXW'(i))) req_m[i] = 1'b0;
        end
        // Concatenating the vector with itself makes the wrap a plain slice.
        dbl = {req_m, req_m};
        rot = '0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            pos    = (IDXW+1)'(start) + (IDXW+1)'(i);
            rot[i] = dbl[pos];
        end
        found = |rot;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDXW'(i);
        end
        sum = (IDXW+1)'(start) + (IDXW+1)'(off);
        if (sum >= (IDXW+1)'(N)) sum = sum - (IDXW+1)'(N);
        idx = sum[IDXW-1:0];
    end
endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with hold limit; grant appears one cycle after request.
// No backpressure: a holder keeps the grant until done, request drop or hold limit.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int IDXW     = clog2(N),
    parameter int MAX_HOLD = 255
) (
    input  logic clk,
    input  logic rst,
    arb_if.slave bus
);
    localparam int HCW = clog2(MAX_HOLD + 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic            gvld_q, gvld_d;
    logic [IDXW-1:0] gidx_q, gidx_d;
    logic [N-1:0]    goh_q, goh_d;
    logic            tmo_q, tmo_d;

    logic            found;
    logic [IDXW-1:0] win_idx;
    logic            normal_rel;
    logic            limit_rel;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] i);
        return (i == IDXW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // While granted, the holder is masked so a pending peer always wins first.
    rr_find_next #(.N(N), .IDXW(IDXW)) u_find (
        .req      (bus.req),
        .start    (ptr_q),
        .mask_idx (gidx_q),
        .use_mask (state_q == ST_GRANT),
        .found    (found),
        .idx      (win_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gvld_d     = gvld_q;
        gidx_d     = gidx_q;
        goh_d      = goh_q;
        tmo_d      = 1'b0;
        normal_rel = bus.done || !bus.req[gidx_q];
        limit_rel  = (hold_q == HCW'(MAX_HOLD - 1));
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    gvld_d  = 1'b1;
                    gidx_d  = win_idx;
                    goh_d   = N'(1) << win_idx;
                    ptr_d   = wrap_inc(win_idx);
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (hold_q != HCW'(MAX_HOLD)) hold_d = hold_q + 1'b1;
                if (normal_rel || limit_rel) begin
                    tmo_d  = !normal_rel;
                    hold_d = '0;
                    if (found) begin
                        gidx_d = win_idx;
                        goh_d  = N'(1) << win_idx;
                        ptr_d  = wrap_inc(win_idx);
                    end else if (!normal_rel) begin
                        ptr_d = wrap_inc(gidx_q);
                    end else begin
                        state_d = ST_IDLE;
                        gvld_d  = 1'b0;
                        gidx_d  = '0;
                        goh_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gvld_q  <= 1'b0;
            gidx_q  <= '0;
            goh_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gvld_q  <= gvld_d;
            gidx_q  <= gidx_d;
            goh_q   <= goh_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.grant_valid  = gvld_q;
    assign bus.grant_idx    = gidx_q;
    assign bus.grant_onehot = goh_q;
    assign bus.timeout      = tmo_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter with N=16, MAX_HOLD=4: vector table plus directed sequences.
module tb_rr_onehot_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    arb_if #(.N(16), .IDXW(4)) bus();

    rr_onehot_arbiter #(.N(16), .IDXW(4), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] req;
        logic        done;
        logic        ev;
        logic [3:0]  ei;
        logic        et;
        int          ptr;
    } vec_t;

    vec_t sbq[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string n, logic r, logic [15:0] q, logic d,
                                logic ev, logic [3:0] ei, logic et, int p);
        vec_t v;
        v.name = n; v.rst = r; v.req = q; v.done = d;
        v.ev = ev; v.ei = ei; v.et = et; v.ptr = p;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst      = v.rst;
        bus.req  = v.req;
        bus.done = v.done;
        sbq.push_back(v);
    endtask

    // Outputs registered at an edge are compared 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                vec_t        e;
                logic [15:0] oh;
                e  = sbq.pop_front();
                oh = e.ev ? (16'h0001 << e.ei) : 16'h0000;
                chk({e.name, ".valid"},   32'(bus.grant_valid),  32'(e.ev));
                chk({e.name, ".idx"},     32'(bus.grant_idx),    32'(e.ev ? e.ei : 4'd0));
                chk({e.name, ".onehot"},  32'(bus.grant_onehot), 32'(oh));
                chk({e.name, ".timeout"}, 32'(bus.timeout),      32'(e.et));
                if (e.ptr >= 0) chk({e.name, ".ptr"}, 32'(dut.ptr_q), 32'(e.ptr));
            end
        end
    end

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;

        tbl[0]  = mk("reset",        1, 16'h0000, 0, 0, 0, 0, 0);
        tbl[1]  = mk("reset_hold",   1, 16'h0000, 0, 0, 0, 0, -1);
        tbl[2]  = mk("t1_grant0",    0, 16'h0001, 0, 1, 0, 0, 1);
        tbl[3]  = mk("t1_done_idle", 0, 16'h0001, 1, 0, 0, 0, 1);
        tbl[4]  = mk("t1_idle",      0, 16'h0000, 0, 0, 0, 0, -1);
        tbl[5]  = mk("t2_reset",     1, 16'h0000, 0, 0, 0, 0, 0);
        tbl[6]  = mk("t2_g0",        0, 16'h0111, 0, 1, 0, 0, 1);
        tbl[7]  = mk("t2_g4",        0, 16'h0111, 1, 1, 4, 0, 5);
        tbl[8]  = mk("t2_g8",        0, 16'h0111, 1, 1, 8, 0, 9);
        tbl[9]  = mk("t2_g0b",       0, 16'h0111, 1, 1, 0, 0, 1);
        tbl[10] = mk("t2_g4b",       0, 16'h0111, 1, 1, 4, 0, 5);
        tbl[11] = mk("t2_g8b",       0, 16'h0111, 1, 1, 8, 0, 9);
        tbl[12] = mk("t2_drop",      0, 16'h0000, 0, 0, 0, 0, 9);

        for (int i = 0; i < 13; i++) step(tbl[i]);

        // Hold limit with a lone requester: re-grant plus timeout pulse.
        step(mk("t3_grant1", 0, 16'h0002, 0, 1, 1, 0, 2));
        for (int i = 0; i < 3; i++) step(mk("t3_hold", 0, 16'h0002, 0, 1, 1, 0, -1));
        step(mk("t3_timeout", 0, 16'h0002, 0, 1, 1, 1, 2));
        for (int i = 0; i < 3; i++) step(mk("t3_hold_b", 0, 16'h0006, 0, 1, 1, 0, -1));
        step(mk("t3_move2", 0, 16'h0006, 0, 1, 2, 1, 3));

        // done coinciding with the hold limit is a normal release.
        for (int i = 0; i < 3; i++) step(mk("t4_hold", 0, 16'h0006, 0, 1, 2, 0, -1));
        step(mk("t4_done_limit", 0, 16'h0006, 1, 1, 1, 0, 2));

        // Holder drops its request with nobody else waiting.
        step(mk("t5_keep", 0, 16'h0002, 0, 1, 1, 0, -1));
        step(mk("t5_drop", 0, 16'h0000, 0, 0, 0, 0, 2));
        step(mk("done_idle", 0, 16'h0000, 1, 0, 0, 0, 2));

        // Reset in the middle of a grant at hold count 3.
        step(mk("t6_grant5", 0, 16'h0020, 0, 1, 5, 0, 6));
        for (int i = 0; i < 3; i++) step(mk("t6_hold", 0, 16'h0020, 0, 1, 5, 0, -1));
        step(mk("t6_reset", 1, 16'h0020, 0, 0, 0, 0, 0));
        step(mk("t6_regrant", 0, 16'h0020, 0, 1, 5, 0, 6));

        // Winner N-1 wraps the pointer to zero.
        step(mk("wrap15", 0, 16'h8020, 1, 1, 15, 0, 0));
        step(mk("wrap0", 0, 16'h8001, 1, 1, 0, 0, 1));
        step(mk("final_idle", 0, 16'h0000, 0, 0, 0, 0, 1));

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
